atto_port_scheduler: RTL and testbench

//  Per-output-port scheduler for the atto router. Shares one output port (south, west or PE)

---
 rtl/atto_port_scheduler.sv | 126 ++++++++++++
 tb/tb_atto_port_scheduler.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/atto_port_scheduler.sv
// Round-robin, credit-gated scheduler for one atto router output port.
// Drives the crossbar select and the two-phase diff-pair flit strobe.
module atto_port_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int CREDITS  = 4,
    parameter int CREDIT_W = 3
) (
    input  logic                clka,
    input  logic                rsta,
    input  logic [NUM_REQ-1:0]  req_din,
    input  logic                credit_return_din,
    output logic [NUM_REQ-1:0]  grant_dout,
    output logic [1:0]          xbar_sel_dout,
    output logic [1:0]          diff_pair_dout,
    output logic [CREDIT_W-1:0] credit_count_dout,
    output logic                stall_dout,
    output logic                credit_err_dout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] STALL = 2'd2;

    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(CREDITS);
    localparam logic [CREDIT_W-1:0] CRED_ONE = CREDIT_W'(1);

    logic [1:0]          state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [1:0]          xsel_q;
    logic [1:0]          dp_q;
    logic [CREDIT_W-1:0] cred_q, cred_d;
    logic                err_q, err_d;

    logic [3:0]          elig;
    logic                elig_any;
    logic                pick_vld;
    logic [1:0]          pick_idx;
    logic [2:0]          scan;
    logic                do_grant;

    // The previous grant masks its owner so a held req is not served twice.
    assign elig     = 4'(req_din & ~grant_q);
    assign elig_any = |elig;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        scan     = 3'd0;
        // Descending scan: the lowest offset from ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr_q} + 3'(k);
            if (scan >= 3'(NUM_REQ))
                scan = scan - 3'(NUM_REQ);
            if (elig[scan[1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[1:0];
            end
        end
    end

    assign do_grant = pick_vld && (cred_q != '0);

    always_comb begin
        grant_d = '0;
        for (int i = 0; i < NUM_REQ; i++)
            grant_d[i] = do_grant && (pick_idx == 2'(i));
    end

    always_comb begin
        ptr_d = ptr_q;
        if (do_grant)
            ptr_d = (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            STALL:   state_d = do_grant ? GRANT : (elig_any ? STALL : IDLE);
            default: state_d = do_grant ? GRANT : (elig_any ? STALL : IDLE);
        endcase
    end

    always_comb begin
        cred_d = cred_q;
        err_d  = err_q;
        if (do_grant && !credit_return_din)
            cred_d = cred_q - CRED_ONE;
        else if (!do_grant && credit_return_din) begin
            if (cred_q == CRED_MAX)
                err_d = 1'b1;
            else
                cred_d = cred_q + CRED_ONE;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            grant_q <= '0;
            xsel_q  <= 2'd0;
            dp_q    <= 2'b10;
            cred_q  <= CRED_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
            if (do_grant) begin
                xsel_q <= pick_idx;
                dp_q   <= ~dp_q;
            end
        end
    end

    assign grant_dout        = grant_q;
    assign xbar_sel_dout     = xsel_q;
    assign diff_pair_dout    = dp_q;
    assign credit_count_dout = cred_q;
    assign stall_dout        = (state_q == STALL);
    assign credit_err_dout   = err_q;

endmodule

// File: tb/tb_atto_port_scheduler.sv
// Directed vector bench for atto_port_scheduler.
// Each record: inputs before an edge, expected outputs just after it.
module tb_atto_port_scheduler;

    logic       clka = 1'b0;
    logic       rsta;
    logic [2:0] req_din;
    logic       credit_return_din;
    logic [2:0] grant_dout;
    logic [1:0] xbar_sel_dout;
    logic [1:0] diff_pair_dout;
    logic [2:0] credit_count_dout;
    logic       stall_dout;
    logic       credit_err_dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       ret;
        logic [2:0] g;
        logic [1:0] x;
        logic [1:0] dp;
        logic [2:0] c;
        logic       st;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    atto_port_scheduler #(
        .NUM_REQ (3),
        .CREDITS (4),
        .CREDIT_W(3)
    ) dut (
        .clka             (clka),
        .rsta             (rsta),
        .req_din          (req_din),
        .credit_return_din(credit_return_din),
        .grant_dout       (grant_dout),
        .xbar_sel_dout    (xbar_sel_dout),
        .diff_pair_dout   (diff_pair_dout),
        .credit_count_dout(credit_count_dout),
        .stall_dout       (stall_dout),
        .credit_err_dout  (credit_err_dout)
    );

    always #5 clka = ~clka;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] req,
                                input logic ret, input logic [2:0] g,
                                input logic [1:0] x, input logic [1:0] dp,
                                input logic [2:0] c, input logic st,
                                input logic err);
        vec_t v;
        v.rst = rst; v.req = req; v.ret = ret;
        v.g = g; v.x = x; v.dp = dp; v.c = c; v.st = st; v.err = err;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        rsta              = v.rst;
        req_din           = v.req;
        credit_return_din = v.ret;
        @(posedge clka);
        #1;
        chk({tag, " grant"}, int'(grant_dout), int'(v.g));
        chk({tag, " xbar_sel"}, int'(xbar_sel_dout), int'(v.x));
        chk({tag, " diff_pair"}, int'(diff_pair_dout), int'(v.dp));
        chk({tag, " credits"}, int'(credit_count_dout), int'(v.c));
        chk({tag, " stall"}, int'(stall_dout), int'(v.st));
        chk({tag, " credit_err"}, int'(credit_err_dout), int'(v.err));
        chk({tag, " onehot"}, int'($countones(grant_dout) <= 1), 1);
    endtask

    initial begin
        rsta              = 1'b1;
        req_din           = 3'b000;
        credit_return_din = 1'b0;
        repeat (20) @(posedge clka);
        #1;
        chk("reset grant", int'(grant_dout), 0);
        chk("reset diff_pair", int'(diff_pair_dout), 2);
        chk("reset credits", int'(credit_count_dout), 4);
        chk("reset stall", int'(stall_dout), 0);
        chk("reset xbar_sel", int'(xbar_sel_dout), 0);
        chk("reset credit_err", int'(credit_err_dout), 0);

        //           rst  req    ret  grant  x    dp     cnt st err
        // single request
        tbl.push_back(mk(0, 3'b001, 0, 3'b001, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 2'b01, 3, 0, 0));
        // all request, return every cycle: rr wraps, count flat
        tbl.push_back(mk(0, 3'b111, 1, 3'b010, 1, 2'b10, 3, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 3'b100, 2, 2'b01, 3, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 3'b001, 0, 2'b10, 3, 0, 0));
        tbl.push_back(mk(0, 3'b111, 1, 3'b010, 1, 2'b01, 3, 0, 0));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 1, 2'b01, 3, 0, 0));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 1, 2'b01, 4, 0, 0));
        // held single request drains credits on alternate cycles
        tbl.push_back(mk(0, 3'b010, 0, 3'b010, 1, 2'b10, 3, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b10, 3, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b010, 1, 2'b01, 2, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b01, 2, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b010, 1, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b010, 1, 2'b01, 0, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b01, 0, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b01, 0, 1, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b01, 0, 1, 0));
        // return at count 0 cannot grant that edge; exactly one grant next
        tbl.push_back(mk(0, 3'b010, 1, 3'b000, 1, 2'b01, 1, 1, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b010, 1, 2'b10, 0, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b10, 0, 0, 0));
        tbl.push_back(mk(0, 3'b010, 0, 3'b000, 1, 2'b10, 0, 1, 0));
        // req drops in STALL -> IDLE, refill to 2
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 1, 2'b10, 1, 0, 0));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 1, 2'b10, 2, 0, 0));
        // grant and return same edge at count 2
        tbl.push_back(mk(0, 3'b001, 1, 3'b001, 0, 2'b01, 2, 0, 0));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 2'b01, 3, 0, 0));
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 2'b01, 4, 0, 0));
        // over-return sets sticky error
        tbl.push_back(mk(0, 3'b000, 1, 3'b000, 0, 2'b01, 4, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 0, 2'b01, 4, 0, 1));
        tbl.push_back(mk(0, 3'b100, 0, 3'b100, 2, 2'b10, 3, 0, 1));
        tbl.push_back(mk(0, 3'b000, 0, 3'b000, 2, 2'b10, 3, 0, 1));

        foreach (tbl[i])
            apply(tbl[i], $sformatf("v%0d", i));

        // reset mid-GRANT at count 1 restores everything, ptr back to 0
        apply(mk(1, 3'b000, 0, 3'b000, 0, 2'b10, 4, 0, 0), "r0");
        apply(mk(0, 3'b001, 0, 3'b001, 0, 2'b01, 3, 0, 0), "r1");
        apply(mk(0, 3'b000, 0, 3'b000, 0, 2'b01, 3, 0, 0), "r2");
        apply(mk(0, 3'b010, 0, 3'b010, 1, 2'b10, 2, 0, 0), "r3");
        apply(mk(0, 3'b000, 0, 3'b000, 1, 2'b10, 2, 0, 0), "r4");
        apply(mk(0, 3'b100, 0, 3'b100, 2, 2'b01, 1, 0, 0), "r5");
        apply(mk(1, 3'b110, 0, 3'b000, 0, 2'b10, 4, 0, 0), "r6");
        apply(mk(0, 3'b110, 0, 3'b010, 1, 2'b01, 3, 0, 0), "r7");
        apply(mk(0, 3'b110, 0, 3'b100, 2, 2'b10, 2, 0, 0), "r8");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
